// File: rtl/booth_pkg.sv
// booth_pkg: shared state/digit types and digit-count helper for the radix-4 Booth multiplier.
package booth_pkg;
   typedef enum logic [1:0] {IDLE, CALC, DONE} booth_state_t;
   typedef enum logic [2:0] {D_ZERO, D_P1, D_P2, D_M1, D_M2} booth_digit_t;
   // Unsigned mode needs one extra digit so the top digit of the zero-extended multiplier is non-negative.
   function automatic int booth_digits(input int width, input logic signed_mode);
      return signed_mode ? width / 2 : width / 2 + 1;
   endfunction
endpackage

// File: rtl/booth_r4_encoder.sv
// booth_r4_encoder: maps a 3-bit multiplier window {x1,x0,q-1} to a radix-4 Booth digit.
module booth_r4_encoder
   import booth_pkg::*;
(
   input  logic [2:0]   win_i,
   output booth_digit_t digit_o
);
   always_comb
      digit_o = (win_i == 3'b001 || win_i == 3'b010) ? D_P1 :
                (win_i == 3'b011)                    ? D_P2 :
                (win_i == 3'b100)                    ? D_M2 :
                (win_i == 3'b101 || win_i == 3'b110) ? D_M1 : D_ZERO;
endmodule

// File: rtl/booth_r4_mult_seq.sv
// booth_r4_mult_seq: iterative radix-4 Booth multiplier, one digit per clock, start/ready/done handshake.
module booth_r4_mult_seq
   import booth_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               signed_mode,
   input  logic [WIDTH-1:0]   operand_a,
   input  logic [WIDTH-1:0]   operand_x,
   input  logic               clear,
   output logic               ready,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);
   localparam int CNT_W = $clog2(WIDTH / 2 + 2);
   localparam int AW    = WIDTH + 3;

   if (WIDTH % 2 != 0 || WIDTH < 4) begin : g_width_chk
      $error("booth_r4_mult_seq: WIDTH must be even and >= 4");
   end

   booth_state_t         state_q;
   booth_digit_t         digit;
   logic                 sm_q, qm1_q, done_q, last;
   logic [WIDTH+1:0]     a_q, x_q;
   logic [AW-1:0]        acc_q, a1, a2, mult, sum;
   logic [CNT_W-1:0]     cnt_q;
   logic [AW+WIDTH+1:0]  shifted;
   logic [2*WIDTH-1:0]   product_q, product_d;

   booth_r4_encoder u_enc (
      .win_i   ({x_q[1:0], qm1_q}),
      .digit_o (digit)
   );

   assign a1 = {a_q[WIDTH+1], a_q};
   assign a2 = {a_q, 1'b0};
   always_comb
      mult = (digit == D_P1) ? a1 :
             (digit == D_P2) ? a2 :
             (digit == D_M1) ? ~a1 + 1'b1 :
             (digit == D_M2) ? ~a2 + 1'b1 : '0;
   assign sum     = acc_q + mult;
   assign shifted = {{2{sum[AW-1]}}, sum, x_q[WIDTH+1:2]};
   assign last    = cnt_q == CNT_W'(booth_digits(WIDTH, sm_q) - 1);
   // Signed runs consume two fewer multiplier bits, leaving the product two bits higher.
   assign product_d = sm_q ? shifted[2*WIDTH+1:2] : shifted[2*WIDTH-1:0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         sm_q      <= 1'b0;
         qm1_q     <= 1'b0;
         done_q    <= 1'b0;
         a_q       <= '0;
         x_q       <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         product_q <= '0;
      end else if (clear) begin
         state_q <= IDLE;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (start) begin
               state_q <= CALC;
               sm_q    <= signed_mode;
               a_q     <= {{2{signed_mode & operand_a[WIDTH-1]}}, operand_a};
               x_q     <= {{2{signed_mode & operand_x[WIDTH-1]}}, operand_x};
               qm1_q   <= 1'b0;
               acc_q   <= '0;
               cnt_q   <= '0;
            end
            CALC: begin
               acc_q <= shifted[AW+WIDTH+1:WIDTH+2];
               x_q   <= shifted[WIDTH+1:0];
               qm1_q <= x_q[1];
               cnt_q <= cnt_q + 1'b1;
               if (last) begin
                  state_q   <= DONE;
                  done_q    <= 1'b1;
                  product_q <= product_d;
               end
            end
            DONE: begin
               state_q <= IDLE;
               done_q  <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign ready   = state_q == IDLE;
   assign busy    = state_q != IDLE;
   assign done    = done_q;
   assign product = product_q;
endmodule
